seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner.sv | 105 ++++++++++
 tb/tb_seven_seg_scanner.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed 7-segment scanner sharing one external BCD decoder.
// Double-buffered display value, leading-zero blanking, per-slot anti-ghost guard.
module seven_seg_scanner #(
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   input  logic [3:0]  dp_mask,
   input  logic        lz_blank,
   input  logic        display_en,
   output logic [3:0]  bcd_out,
   input  logic [7:0]  seg_in,
   output logic [7:0]  seg_out,
   output logic [3:0]  digit_an
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);

   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       index_q, index_d;
   logic [15:0]      active_q, active_d;
   logic [15:0]      pending_q, pending_d;
   logic             pend_full_q, pend_full_d;
   logic [7:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;

   logic             slot_end, frame_end;
   logic             blank3, blank2, blank1;
   logic [3:0]       blank_vec;
   logic             cur_blank;
   logic [3:0]       cur_nib;

   // A digit is blanked only if it and every digit to its left are zero.
   assign blank3    = lz_blank && (active_q[15:12] == 4'd0);
   assign blank2    = blank3 && (active_q[11:8] == 4'd0);
   assign blank1    = blank2 && (active_q[7:4] == 4'd0);
   assign blank_vec = {blank3, blank2, blank1, 1'b0};
   assign cur_blank = blank_vec[index_q];
   assign cur_nib   = active_q[{index_q, 2'b00} +: 4];

   assign bcd_out    = cur_blank ? 4'hF : cur_nib;
   assign load_ready = ~pend_full_q;
   assign seg_out    = seg_q;
   assign digit_an   = an_q;

   assign slot_end  = (count_q == CNT_LAST);
   assign frame_end = slot_end && (index_q == 2'd3);

   always_comb begin
      count_d     = slot_end ? '0 : count_q + 1'b1;
      index_d     = slot_end ? index_q + 2'd1 : index_q;
      active_d    = active_q;
      pending_d   = pending_q;
      pend_full_d = pend_full_q;
      seg_d       = 8'hFF;
      an_d        = 4'hF;

      // Swap only between frames so a value never appears half-updated.
      if (frame_end && pend_full_q) begin
         active_d    = pending_q;
         pend_full_d = 1'b0;
      end else if (load_valid && !pend_full_q) begin
         pending_d   = load_data;
         pend_full_d = 1'b1;
      end

      if (display_en) begin
         seg_d    = seg_in;
         seg_d[7] = seg_in[7] & ~(dp_mask[index_q] & ~cur_blank);
         if (count_q >= CNT_GUARD) begin
            an_d = ~(4'b0001 << index_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         index_q     <= 2'd0;
         active_q    <= 16'h0000;
         pend_full_q <= 1'b0;
         seg_q       <= 8'hFF;
         an_q        <= 4'hF;
      end else begin
         count_q     <= count_d;
         index_q     <= index_d;
         active_q    <= active_d;
         pend_full_q <= pend_full_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   // Pending data is qualified by pend_full_q, so it needs no reset.
   always_ff @(posedge clk) begin
      pending_q <= pending_d;
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with a behavioural decoder and a
// frame-time reference model of the display buffer.
module tb_seven_seg_scanner;

   localparam int RD    = 8;
   localparam int GC    = 2;
   localparam int FRAME = 4 * RD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;
   logic [3:0]  dp_mask;
   logic        lz_blank;
   logic        display_en;
   logic [3:0]  bcd_out;
   logic [7:0]  seg_in;
   logic [7:0]  seg_out;
   logic [3:0]  digit_an;

   int checks   = 0;
   int failures = 0;

   int          cyc;
   logic [15:0] act, pend;
   bit          pfull, accepted, exp_rdy;
   logic [7:0]  exp_seg;
   logic [3:0]  exp_an, exp_bcd;

   seven_seg_scanner #(.REFRESH_DIV(RD), .GUARD_CYCLES(GC)) dut (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .dp_mask(dp_mask), .lz_blank(lz_blank),
      .display_en(display_en), .bcd_out(bcd_out), .seg_in(seg_in),
      .seg_out(seg_out), .digit_an(digit_an)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] dec7(input logic [3:0] d);
      case (d)
         4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
         4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
         4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
         4'd9: return 8'h90;  default: return 8'hFF;
      endcase
   endfunction

   assign seg_in = dec7(bcd_out);

   function automatic bit is_blank(input logic [15:0] v, input int i, input bit lz);
      if (!lz || i == 0) return 1'b0;
      for (int j = i; j < 4; j++) if (v[j*4 +: 4] != 4'd0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [3:0] model_bcd(input logic [15:0] v, input int i, input bit lz);
      return is_blank(v, i, lz) ? 4'hF : v[i*4 +: 4];
   endfunction

   function automatic logic [7:0] model_seg(input logic [15:0] v, input int i, input bit lz,
                                            input logic [3:0] dp);
      logic [7:0] s;
      s = dec7(model_bcd(v, i, lz));
      if (dp[i] && !is_blank(v, i, lz)) s[7] = 1'b0;
      return s;
   endfunction

   // Advance one clock; expectations derive from elapsed time since reset.
   task automatic step();
      int cnt, idx;
      bit frame_end, take;
      cnt       = cyc % RD;
      idx       = (cyc / RD) % 4;
      frame_end = (cyc % FRAME) == FRAME - 1;
      exp_an    = (cnt < GC || !display_en) ? 4'hF : ~(4'b0001 << idx);
      exp_seg   = display_en ? model_seg(act, idx, lz_blank, dp_mask) : 8'hFF;
      take      = load_valid && !pfull;
      @(posedge clk);
      #1;
      if (frame_end && pfull) begin
         act   = pend;
         pfull = 1'b0;
      end else if (take) begin
         pend  = load_data;
         pfull = 1'b1;
      end
      accepted = take;
      cyc++;
      exp_rdy = !pfull;
      exp_bcd = model_bcd(act, (cyc / RD) % 4, lz_blank);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (seg_out !== 8'hFF || digit_an !== 4'hF || load_ready !== 1'b1 || bcd_out !== 4'h0) begin
         failures++;
         $display("FAIL reset seg=%h an=%h rdy=%b bcd=%h want FF F 1 0", seg_out, digit_an, load_ready, bcd_out);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0; act = 16'h0; pend = 16'h0; pfull = 1'b0;
   endtask

   task automatic test_idle_scan();
      int lowcnt [4];
      display_en = 1'b1; lz_blank = 1'b0; dp_mask = 4'h0; load_valid = 1'b0;
      for (int i = 0; i < 4; i++) lowcnt[i] = 0;
      for (int n = 0; n < 2 * FRAME; n++) begin
         step();
         for (int i = 0; i < 4; i++) if (digit_an[i] === 1'b0) lowcnt[i]++;
         checks++;
         if (digit_an !== exp_an || seg_out !== exp_seg) begin
            failures++;
            $display("FAIL idle_scan cyc=%0d an=%h seg=%h want %h %h", cyc, digit_an, seg_out, exp_an, exp_seg);
         end
         if (digit_an !== 4'hF) begin
            checks++;
            if (seg_out !== 8'hC0) begin
               failures++;
               $display("FAIL idle_zero cyc=%0d seg=%h want C0", cyc, seg_out);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (lowcnt[i] != 2 * (RD - GC)) begin
            failures++;
            $display("FAIL idle_duty an%0d low=%0d want %0d", i, lowcnt[i], 2 * (RD - GC));
         end
      end
   endtask

   task automatic test_load();
      int n;
      n = 0;
      while (cyc % FRAME != 10 && n < 2 * FRAME) begin step(); n++; end
      load_data = 16'h1234; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      checks++;
      if (load_ready !== 1'b0 || !accepted) begin
         failures++;
         $display("FAIL load_accept rdy=%b want 0", load_ready);
      end
      n = 0;
      while (load_ready !== 1'b1 && n < 3 * FRAME) begin
         step(); n++;
         checks++;
         if (seg_out !== exp_seg || digit_an !== exp_an || load_ready !== exp_rdy) begin
            failures++;
            $display("FAIL load_old cyc=%0d seg=%h an=%h rdy=%b want %h %h %b", cyc, seg_out, digit_an, load_ready, exp_seg, exp_an, exp_rdy);
         end
      end
      checks++;
      if (load_ready !== 1'b1 || bcd_out !== 4'h4) begin
         failures++;
         $display("FAIL load_swap rdy=%b bcd=%h want 1 4", load_ready, bcd_out);
      end
      for (n = 0; n < FRAME; n++) begin
         step();
         checks++;
         if (seg_out !== exp_seg || digit_an !== exp_an || bcd_out !== exp_bcd) begin
            failures++;
            $display("FAIL load_new cyc=%0d seg=%h an=%h bcd=%h want %h %h %h", cyc, seg_out, digit_an, bcd_out, exp_seg, exp_an, exp_bcd);
         end
      end
   endtask

   task automatic test_lz();
      logic [15:0] vals [2];
      int n;
      vals[0] = 16'h0070; vals[1] = 16'h0000;
      lz_blank = 1'b1;
      for (int v = 0; v < 2; v++) begin
         load_data = vals[v]; load_valid = 1'b1;
         step();
         load_valid = 1'b0;
         n = 0;
         while (load_ready !== 1'b1 && n < 3 * FRAME) begin step(); n++; end
         checks++;
         if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL lz_timeout val=%h rdy=%b want 1", vals[v], load_ready);
         end
         for (n = 0; n < FRAME; n++) begin
            step();
            checks++;
            if (seg_out !== exp_seg || digit_an !== exp_an || bcd_out !== exp_bcd) begin
               failures++;
               $display("FAIL lz_model val=%h cyc=%0d seg=%h an=%h bcd=%h want %h %h %h", vals[v], cyc, seg_out, digit_an, bcd_out, exp_seg, exp_an, exp_bcd);
            end
            if (exp_an == 4'h7 || exp_an == 4'hB || (exp_an == 4'hD && v == 1)) begin
               checks++;
               if (seg_out !== 8'hFF) begin
                  failures++;
                  $display("FAIL lz_blank val=%h an=%h seg=%h want FF", vals[v], exp_an, seg_out);
               end
            end
            if (exp_an == 4'hE) begin
               checks++;
               if (seg_out !== 8'hC0) begin
                  failures++;
                  $display("FAIL lz_digit0 val=%h seg=%h want C0", vals[v], seg_out);
               end
            end
         end
      end
      lz_blank = 1'b0;
   endtask

   task automatic test_collision();
      int n;
      while (cyc % FRAME != 5) step();
      load_data = 16'h5678; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      while (cyc % FRAME != FRAME - 1) step();
      load_data = 16'h9021; load_valid = 1'b1;
      checks++;
      if (load_ready !== 1'b0) begin
         failures++;
         $display("FAIL coll_full rdy=%b want 0", load_ready);
      end
      step();
      checks++;
      if (accepted || load_ready !== 1'b1 || bcd_out !== 4'h8) begin
         failures++;
         $display("FAIL coll_swap rdy=%b bcd=%h want 1 8", load_ready, bcd_out);
      end
      n = 0;
      while (!accepted && n < 8) begin step(); n++; end
      load_valid = 1'b0;
      checks++;
      if (load_ready !== 1'b0) begin
         failures++;
         $display("FAIL coll_second rdy=%b want 0", load_ready);
      end
      for (n = 0; n < 2 * FRAME; n++) begin
         step();
         checks++;
         if (seg_out !== exp_seg || digit_an !== exp_an || load_ready !== exp_rdy || bcd_out !== exp_bcd) begin
            failures++;
            $display("FAIL coll_model cyc=%0d seg=%h an=%h rdy=%b bcd=%h want %h %h %b %h", cyc, seg_out, digit_an, load_ready, bcd_out, exp_seg, exp_an, exp_rdy, exp_bcd);
         end
      end
   endtask

   task automatic test_boundary_load();
      while (cyc % FRAME != FRAME - 1 || load_ready !== 1'b1) step();
      load_data = 16'h4321; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int n = 0; n < FRAME - 1; n++) step();
      checks++;
      if (load_ready !== 1'b0 || bcd_out !== exp_bcd) begin
         failures++;
         $display("FAIL bnd_hold rdy=%b bcd=%h want 0 %h", load_ready, bcd_out, exp_bcd);
      end
      step();
      checks++;
      if (load_ready !== 1'b1 || bcd_out !== 4'h1) begin
         failures++;
         $display("FAIL bnd_swap rdy=%b bcd=%h want 1 1", load_ready, bcd_out);
      end
   endtask

   task automatic test_dp_en();
      load_data = 16'h1250; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      while (load_ready !== 1'b1 && cyc < 20000) step();
      dp_mask = 4'b0100;
      for (int n = 0; n < FRAME; n++) begin
         step();
         checks++;
         if (seg_out !== exp_seg || digit_an !== exp_an) begin
            failures++;
            $display("FAIL dp_model cyc=%0d seg=%h an=%h want %h %h", cyc, seg_out, digit_an, exp_seg, exp_an);
         end
         if (exp_an != 4'hF) begin
            checks++;
            if (seg_out[7] !== (exp_an != 4'hB)) begin
               failures++;
               $display("FAIL dp_bit an=%h seg7=%b want %b", exp_an, seg_out[7], exp_an != 4'hB);
            end
         end
      end
      display_en = 1'b0;
      for (int n = 0; n < RD + 3; n++) begin
         step();
         checks++;
         if (seg_out !== 8'hFF || digit_an !== 4'hF) begin
            failures++;
            $display("FAIL dark seg=%h an=%h want FF F", seg_out, digit_an);
         end
      end
      display_en = 1'b1;
      for (int n = 0; n < FRAME; n++) begin
         step();
         checks++;
         if (seg_out !== exp_seg || digit_an !== exp_an) begin
            failures++;
            $display("FAIL relight cyc=%0d seg=%h an=%h want %h %h", cyc, seg_out, digit_an, exp_seg, exp_an);
         end
      end
      dp_mask = 4'h0;
   endtask

   task automatic test_random();
      logic [15:0] d;
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < 4; k++)
            d[k*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
         load_data  = d;
         load_valid = ($urandom_range(0, 3) == 0);
         dp_mask    = 4'($urandom_range(0, 15));
         lz_blank   = ($urandom_range(0, 1) == 1);
         display_en = ($urandom_range(0, 9) != 0);
         step();
         checks++;
         if (seg_out !== exp_seg || digit_an !== exp_an || load_ready !== exp_rdy || bcd_out !== exp_bcd) begin
            failures++;
            $display("FAIL random cyc=%0d seg=%h an=%h rdy=%b bcd=%h want %h %h %b %h", cyc, seg_out, digit_an, load_ready, bcd_out, exp_seg, exp_an, exp_rdy, exp_bcd);
         end
      end
      load_valid = 1'b0; dp_mask = 4'h0; lz_blank = 1'b0; display_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int n;
      n = 0;
      while (load_ready !== 1'b1 && n < 3 * FRAME) begin step(); n++; end
      while (cyc % RD != 3) step();
      load_data = 16'h8888; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (seg_out !== 8'hFF || digit_an !== 4'hF || load_ready !== 1'b1 || bcd_out !== 4'h0) begin
         failures++;
         $display("FAIL async_reset seg=%h an=%h rdy=%b bcd=%h want FF F 1 0", seg_out, digit_an, load_ready, bcd_out);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0; act = 16'h0; pend = 16'h0; pfull = 1'b0;
      for (n = 0; n < 2 * FRAME; n++) begin
         step();
         checks++;
         if (seg_out !== exp_seg || digit_an !== exp_an || load_ready !== exp_rdy) begin
            failures++;
            $display("FAIL post_reset cyc=%0d seg=%h an=%h rdy=%b want %h %h %b", cyc, seg_out, digit_an, load_ready, exp_seg, exp_an, exp_rdy);
         end
         if (n == 2) begin
            checks++;
            if (digit_an !== 4'hE) begin
               failures++;
               $display("FAIL first_slot an=%h want E", digit_an);
            end
         end
         if (digit_an !== 4'hF) begin
            checks++;
            if (seg_out !== 8'hC0) begin
               failures++;
               $display("FAIL stale_pending seg=%h want C0", seg_out);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b1; load_valid = 1'b0; load_data = 16'h0; dp_mask = 4'h0;
      lz_blank = 1'b0; display_en = 1'b1;
      cyc = 0; act = 16'h0; pend = 16'h0; pfull = 1'b0; accepted = 1'b0;
      exp_rdy = 1'b1; exp_seg = 8'hFF; exp_an = 4'hF; exp_bcd = 4'h0;
      test_reset();
      test_idle_scan();
      test_load();
      test_lz();
      test_collision();
      test_boundary_load();
      test_dp_en();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
